// File: rtl/arbitro_consumatore.sv
// Round-robin arbiter sharing one dav_/rfd consumer among N producers.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module arbitro_consumatore #(
    parameter int N       = 3,
    parameter int W       = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic [N-1:0]   dav_in_,
    input  logic [N*W-1:0] x_in,
    input  logic [N*W-1:0] y_in,
    output logic [N-1:0]   rfd_out,
    output logic           dav_out_,
    output logic [W-1:0]   x_out,
    output logic [W-1:0]   y_out,
    input  logic           rfd_in,
    output logic [1:0]     grant,
    output logic           busy,
    output logic           err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic [N-1:0] rfd_q, rfd_d;
    logic         dav_q, dav_d;
    logic         busy_q, busy_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;

    // Requests and data padded to four producers so every index is 2 bits wide.
    logic [3:0]     req;
    logic [4*W-1:0] xp, yp;
    logic           sel_found;
    logic [1:0]     sel_idx;
    logic [2:0]     cand;
    logic [W-1:0]   x_sel, y_sel;
    logic           timeout_hit;

    assign req = 4'(~dav_in_);
    assign xp  = (4*W)'(x_in);
    assign yp  = (4*W)'(y_in);

    // Search starts just after the last grant, so the last-served producer comes last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_q;
        cand      = 3'd0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, grant_q} + 3'(k);
            if (cand >= 3'(N)) cand = cand - 3'(N);
            if (!sel_found && req[cand[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[1:0];
            end
        end
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel_idx == 2'(i)) begin
                x_sel = xp[i*W +: W];
                y_sel = yp[i*W +: W];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int W_T = $clog2(TIMEOUT + 1);
    logic [W_T-1:0] cnt_q, cnt_d;
    logic           err_q;

    assign cnt_d       = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    assign timeout_hit = (state_q != S_IDLE) && (cnt_q == W_T'(TIMEOUT));
    assign err         = err_q;

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rfd_d   = rfd_q;
        dav_d   = dav_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (rfd_in && sel_found) begin
                    grant_d = sel_idx;
                    x_d     = x_sel;
                    y_d     = y_sel;
                    dav_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!rfd_in) begin
                    for (int i = 0; i < N; i++) begin
                        if (grant_q == 2'(i)) rfd_d[i] = 1'b0;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req[grant_q]) begin
                    dav_d   = 1'b1;
                    state_d = S_END;
                end
            end
            default: begin
                if (rfd_in) begin
                    rfd_d   = '1;
                    state_d = S_IDLE;
                end
            end
        endcase
        // Watchdog abort keeps grant so the stuck producer drops to lowest priority.
        if (timeout_hit) begin
            dav_d   = 1'b1;
            rfd_d   = '1;
            state_d = S_IDLE;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state_q <= S_IDLE;
            grant_q <= 2'(N - 1);
            rfd_q   <= '1;
            dav_q   <= 1'b1;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rfd_q   <= rfd_d;
            dav_q   <= dav_d;
            busy_q  <= busy_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign rfd_out  = rfd_q;
    assign dav_out_ = dav_q;
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_arbitro_consumatore.sv
// Directed bench for arbitro_consumatore (N=3, W=3).
module tb_arbitro_consumatore;
    localparam int N = 3;
    localparam int W = 3;

    logic           clock = 1'b0;
    logic           reset_;
    logic [N-1:0]   dav_in_;
    logic [N*W-1:0] x_in, y_in;
    logic [N-1:0]   rfd_out;
    logic           dav_out_;
    logic [W-1:0]   x_out, y_out;
    logic           rfd_in;
    logic [1:0]     grant;
    logic           busy, err;

    int tot = 0;
    int bad = 0;

    arbitro_consumatore #(.N(N), .W(W), .TIMEOUT(15)) dut (
        .clock(clock), .reset_(reset_), .dav_in_(dav_in_), .x_in(x_in), .y_in(y_in),
        .rfd_out(rfd_out), .dav_out_(dav_out_), .x_out(x_out), .y_out(y_out),
        .rfd_in(rfd_in), .grant(grant), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_ = 1'b1;
        step();
        reset_ = 1'b0;
    endtask

    function automatic logic [8:0] pack3(input logic [2:0] a0, input logic [2:0] a1,
                                         input logic [2:0] a2);
        return {a2, a1, a0};
    endfunction

    // One complete handshake with the expected grant; producer re-requests at the end.
    task automatic xfer(input logic [1:0] exp_g);
        int n = 0;
        while (dav_out_ !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("rr_dav", 32'(dav_out_), 32'd0);
        chk("rr_grant", 32'(grant), 32'(exp_g));
        rfd_in = 1'b0;
        step();
        chk("rr_rfd_low", 32'(rfd_out), 32'(3'b111 & ~(3'b001 << exp_g)));
        dav_in_[exp_g] = 1'b1;
        step();
        chk("rr_dav_rel", 32'(dav_out_), 32'd1);
        rfd_in = 1'b1;
        dav_in_[exp_g] = 1'b0;
        step();
        chk("rr_rfd_back", 32'(rfd_out), 32'b111);
    endtask

    initial begin
        int n;
        reset_  = 1'b1;
        dav_in_ = '1;
        x_in    = '0;
        y_in    = '0;
        rfd_in  = 1'b1;
        step();
        chk("rst_dav", 32'(dav_out_), 32'd1);
        chk("rst_rfd", 32'(rfd_out), 32'b111);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_grant", 32'(grant), 32'd2);
        reset_ = 1'b0;

        // Single producer 1 transfer
        x_in    = pack3(3'd0, 3'd2, 3'd0);
        y_in    = pack3(3'd0, 3'd5, 3'd0);
        dav_in_ = 3'b101;
        step();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_dav", 32'(dav_out_), 32'd0);
        chk("t1_x", 32'(x_out), 32'd2);
        chk("t1_y", 32'(y_out), 32'd5);
        chk("t1_busy", 32'(busy), 32'd1);
        rfd_in = 1'b0;
        step();
        chk("t1_rfd_ack", 32'(rfd_out), 32'b101);
        dav_in_ = 3'b111;
        step();
        chk("t1_dav_rel", 32'(dav_out_), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd1);
        rfd_in = 1'b1;
        step();
        chk("t1_rfd_idle", 32'(rfd_out), 32'b111);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Round-robin fairness with all producers pending
        do_reset();
        x_in    = pack3(3'd1, 3'd2, 3'd3);
        dav_in_ = 3'b000;
        for (int t = 0; t < 6; t++) xfer(2'(t % 3));

        // Data latched at grant is unaffected by later producer changes
        do_reset();
        dav_in_ = 3'b110;
        x_in    = pack3(3'd3, 3'd0, 3'd0);
        y_in    = pack3(3'd4, 3'd0, 3'd0);
        step();
        chk("t3_grant", 32'(grant), 32'd0);
        chk("t3_x_grant", 32'(x_out), 32'd3);
        x_in = pack3(3'd7, 3'd0, 3'd0);
        step();
        chk("t3_x_req", 32'(x_out), 32'd3);
        rfd_in = 1'b0;
        step();
        chk("t3_x_ack", 32'(x_out), 32'd3);
        dav_in_ = 3'b111;
        step();
        chk("t3_x_end", 32'(x_out), 32'd3);
        rfd_in = 1'b1;
        step();
        chk("t3_x_idle", 32'(x_out), 32'd3);
        chk("t3_y_idle", 32'(y_out), 32'd4);

        // Asynchronous reset in S_ACK
        dav_in_ = 3'b101;
        step();
        chk("t4_grant", 32'(grant), 32'd1);
        rfd_in = 1'b0;
        step();
        chk("t4_in_ack", 32'(rfd_out), 32'b101);
        #2 reset_ = 1'b1;
        #1;
        chk("t4_async_dav", 32'(dav_out_), 32'd1);
        chk("t4_async_rfd", 32'(rfd_out), 32'b111);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_grant", 32'(grant), 32'd2);
        #2 reset_ = 1'b0;
        dav_in_ = 3'b100;
        rfd_in  = 1'b1;
        step();
        chk("t4_next_grant", 32'(grant), 32'd0);
        chk("t4_next_dav", 32'(dav_out_), 32'd0);

        // Consumer not ready: no grant until rfd_in rises
        do_reset();
        rfd_in  = 1'b0;
        dav_in_ = 3'b000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_idle_busy", 32'(busy), 32'd0);
            chk("t5_idle_dav", 32'(dav_out_), 32'd1);
        end
        rfd_in = 1'b1;
        step();
        chk("t5_grant_dav", 32'(dav_out_), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);

        // Consumer never drops rfd_in after the grant
        dav_in_ = 3'b100;
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("t6_err_pulse", 32'(err), 32'd1);
        chk("t6_abort_dav", 32'(dav_out_), 32'd1);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_rfd", 32'(rfd_out), 32'b111);
        step();
        chk("t6_err_clear", 32'(err), 32'd0);
        chk("t6_next_grant", 32'(grant), 32'd1);
        chk("t6_next_dav", 32'(dav_out_), 32'd0);
`else
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (err !== 1'b0) n++;
        end
        chk("t6_err_never", 32'(n), 32'd0);
        chk("t6_wait_dav", 32'(dav_out_), 32'd0);
        chk("t6_wait_busy", 32'(busy), 32'd1);
        chk("t6_wait_grant", 32'(grant), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
